// File: rtl/bus_pkg.sv
// Shared bus-source definitions: source indices and select codes for the
// datapath bus arbiter and multiplexer.
package bus_pkg;

    localparam int NUM_BUS_SRC = 24;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_C      = 23;

    // Select code is source index + 1; zero means nothing drives the bus.
    localparam int SEL_NONE   = 0;
    localparam int SEL_R0     = 1;
    localparam int SEL_R1     = 2;
    localparam int SEL_R2     = 3;
    localparam int SEL_R3     = 4;
    localparam int SEL_R4     = 5;
    localparam int SEL_R5     = 6;
    localparam int SEL_R6     = 7;
    localparam int SEL_R7     = 8;
    localparam int SEL_R8     = 9;
    localparam int SEL_R9     = 10;
    localparam int SEL_R10    = 11;
    localparam int SEL_R11    = 12;
    localparam int SEL_R12    = 13;
    localparam int SEL_R13    = 14;
    localparam int SEL_R14    = 15;
    localparam int SEL_R15    = 16;
    localparam int SEL_HI     = 17;
    localparam int SEL_LO     = 18;
    localparam int SEL_ZHI    = 19;
    localparam int SEL_ZLO    = 20;
    localparam int SEL_PC     = 21;
    localparam int SEL_MDR    = 22;
    localparam int SEL_INPORT = 23;
    localparam int SEL_C      = 24;

endpackage

// File: rtl/bus_prio_pick.sv
// Combinational lowest-index picker: reports whether any bit is set and the
// index of the lowest set bit.
module bus_prio_pick #(
    parameter int N = 24,
    parameter int W = 5
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_src_arbiter.sv
// Registered bus-source arbiter (fixed priority or round-robin) with hold and
// multi-drive conflict flagging; BUS_CONFLICT_CNT_EN adds a saturating conflict counter.
module bus_src_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_SRC = NUM_BUS_SRC,
    parameter int SEL_W   = $clog2(NUM_SRC + 1),
    parameter int RR_MODE = 0
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               hold,
    input  logic               conflict_ack,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic [NUM_SRC-1:0] grant,
    output logic               conflict,
    output logic               conflict_sticky
`ifdef BUS_CONFLICT_CNT_EN
    ,
    output logic [7:0]         conflict_count
`endif
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [IDX_W-1:0]   last_ptr;
    logic [NUM_SRC-1:0] rr_mask;
    logic               m_found, u_found, pick_found;
    logic [IDX_W-1:0]   m_idx, u_idx, pick_idx;
    logic               held, multi;

    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rr_mask[i] = (i > int'(last_ptr));
        end
    end

    bus_prio_pick #(.N(NUM_SRC), .W(IDX_W)) u_pick_masked (
        .req   (src_req & rr_mask),
        .found (m_found),
        .index (m_idx)
    );

    bus_prio_pick #(.N(NUM_SRC), .W(IDX_W)) u_pick_full (
        .req   (src_req),
        .found (u_found),
        .index (u_idx)
    );

    // Round-robin prefers requests above the last winner, else wraps to the lowest.
    assign pick_found = u_found;
    assign pick_idx   = ((RR_MODE != 0) && m_found) ? m_idx : u_idx;

    assign held  = hold & sel_valid;
    assign multi = |(src_req & (src_req - NUM_SRC'(1)));

    always_ff @(posedge clock) begin
        if (clear) begin
            sel             <= '0;
            sel_valid       <= 1'b0;
            grant           <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            last_ptr        <= IDX_W'(NUM_SRC - 1);
        end else begin
            conflict <= ~held & multi;
            if (~held & multi) begin
                conflict_sticky <= 1'b1;
            end else if (conflict_ack) begin
                conflict_sticky <= 1'b0;
            end
            if (!held) begin
                if (pick_found) begin
                    sel       <= SEL_W'(pick_idx) + SEL_W'(1);
                    sel_valid <= 1'b1;
                    grant     <= NUM_SRC'(1) << pick_idx;
                    last_ptr  <= pick_idx;
                end else begin
                    sel       <= '0;
                    sel_valid <= 1'b0;
                    grant     <= '0;
                end
            end
        end
    end

`ifdef BUS_CONFLICT_CNT_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            conflict_count <= '0;
        end else if (~held & multi & (conflict_count != 8'hFF)) begin
            conflict_count <= conflict_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Directed bench for bus_src_arbiter: one fixed-priority and one round-robin instance.
module tb_bus_src_arbiter;

    logic        clock = 1'b0;
    logic        clear;
    logic [23:0] req_fp, req_rr;
    logic        hold_fp, hold_rr, ack_fp, ack_rr;
    logic [4:0]  fp_sel, rr_sel;
    logic        fp_valid, rr_valid, fp_conf, rr_conf, fp_sticky, rr_sticky;
    logic [23:0] fp_grant, rr_grant;
`ifdef BUS_CONFLICT_CNT_EN
    logic [7:0]  fp_count, rr_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] fp_obs, rr_obs, exp_v;
    assign fp_obs = {fp_sel, fp_valid, fp_grant, fp_conf, fp_sticky};
    assign rr_obs = {rr_sel, rr_valid, rr_grant, rr_conf, rr_sticky};

    always #5 clock = ~clock;

    bus_src_arbiter #(.RR_MODE(0)) u_fp (
        .clock(clock), .clear(clear), .src_req(req_fp), .hold(hold_fp),
        .conflict_ack(ack_fp), .sel(fp_sel), .sel_valid(fp_valid),
        .grant(fp_grant), .conflict(fp_conf), .conflict_sticky(fp_sticky)
`ifdef BUS_CONFLICT_CNT_EN
        , .conflict_count(fp_count)
`endif
    );

    bus_src_arbiter #(.RR_MODE(1)) u_rr (
        .clock(clock), .clear(clear), .src_req(req_rr), .hold(hold_rr),
        .conflict_ack(ack_rr), .sel(rr_sel), .sel_valid(rr_valid),
        .grant(rr_grant), .conflict(rr_conf), .conflict_sticky(rr_sticky)
`ifdef BUS_CONFLICT_CNT_EN
        , .conflict_count(rr_count)
`endif
    );

    // Fields: {sel[4:0], sel_valid, grant[23:0], conflict, conflict_sticky}
    function automatic logic [31:0] ev(input int s, input logic v, input logic [23:0] g,
                                       input logic c, input logic st);
        return {5'(s), v, g, c, st};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        req_fp = '0; req_rr = '0;
        hold_fp = 0; hold_rr = 0; ack_fp = 0; ack_rr = 0;
        step();
        step();
        exp_v = ev(0, 0, 24'h0, 0, 0);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL reset_fp: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (rr_obs !== exp_v) $display("FAIL reset_rr: got %h want %h", rr_obs, exp_v);
        else pass_cnt++;
        clear = 1'b0;
    endtask

    task automatic test_fixed_single();
        req_fp = 24'h1 << 20;
        step();
        exp_v = ev(21, 1, 24'h1 << 20, 0, 0);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL fixed_pc: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_fixed_conflict();
        req_fp = (24'h1 << 3) | (24'h1 << 21);
        step();
        exp_v = ev(4, 1, 24'h1 << 3, 1, 1);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL conflict_set: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        req_fp = '0; ack_fp = 1;
        step();
        exp_v = ev(0, 0, 24'h0, 0, 0);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL conflict_ack: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        req_fp = (24'h1 << 3) | (24'h1 << 21);
        step();
        exp_v = ev(4, 1, 24'h1 << 3, 1, 1);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL set_beats_ack: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        req_fp = '0;
        step();
        ack_fp = 0;
    endtask

    task automatic test_hold();
        req_fp = 24'h1 << 21;
        step();
        exp_v = ev(22, 1, 24'h1 << 21, 0, 0);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL hold_grant_mdr: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        hold_fp = 1;
        for (int i = 0; i < 4; i++) begin
            req_fp = (i == 3) ? ((24'h1 << 1) | (24'h1 << 4)) : (24'h1 << 1);
            step();
            total_cnt++;
            if (fp_obs !== exp_v) $display("FAIL hold_keep_%0d: got %h want %h", i, fp_obs, exp_v);
            else pass_cnt++;
        end
        hold_fp = 0; req_fp = 24'h1 << 1;
        step();
        exp_v = ev(2, 1, 24'h1 << 1, 0, 0);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL hold_release: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        req_fp = '0;
        step();
        hold_fp = 1; req_fp = 24'h1 << 7;
        step();
        exp_v = ev(8, 1, 24'h1 << 7, 0, 0);
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL hold_no_valid: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        req_fp = 24'h1 << 2;
        step();
        total_cnt++;
        if (fp_obs !== exp_v) $display("FAIL hold_same_edge: got %h want %h", fp_obs, exp_v);
        else pass_cnt++;
        hold_fp = 0; req_fp = '0;
        step();
    endtask

    task automatic test_rr_rotate();
        int exp_sel[4] = '{1, 6, 24, 1};
        int exp_idx[4] = '{0, 5, 23, 0};
        req_rr = 24'h1 | (24'h1 << 5) | (24'h1 << 23);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_v = ev(exp_sel[i], 1, 24'h1 << exp_idx[i], 1, 1);
            total_cnt++;
            if (rr_obs !== exp_v) $display("FAIL rr_rotate_%0d: got %h want %h", i, rr_obs, exp_v);
            else pass_cnt++;
        end
        req_rr = '0;
        step();
        exp_v = ev(0, 0, 24'h0, 0, 1);
        total_cnt++;
        if (rr_obs !== exp_v) $display("FAIL rr_idle: got %h want %h", rr_obs, exp_v);
        else pass_cnt++;
        req_rr = 24'h1 | (24'h1 << 5);
        step();
        exp_v = ev(6, 1, 24'h1 << 5, 1, 1);
        total_cnt++;
        if (rr_obs !== exp_v) $display("FAIL rr_after_idle: got %h want %h", rr_obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_clear_mid_hold();
        req_rr = 24'h1 << 9;
        step();
        exp_v = ev(10, 1, 24'h1 << 9, 0, 1);
        total_cnt++;
        if (rr_obs !== exp_v) $display("FAIL rr_grant_r9: got %h want %h", rr_obs, exp_v);
        else pass_cnt++;
        hold_rr = 1; req_rr = (24'h1 << 2) | (24'h1 << 9); clear = 1;
        step();
        exp_v = ev(0, 0, 24'h0, 0, 0);
        total_cnt++;
        if (rr_obs !== exp_v) $display("FAIL clear_mid_hold: got %h want %h", rr_obs, exp_v);
        else pass_cnt++;
        clear = 0; req_rr = (24'h1 << 3) | (24'h1 << 12);
        step();
        exp_v = ev(4, 1, 24'h1 << 3, 1, 1);
        total_cnt++;
        if (rr_obs !== exp_v) $display("FAIL rr_post_clear: got %h want %h", rr_obs, exp_v);
        else pass_cnt++;
        hold_rr = 0; req_rr = '0;
        step();
    endtask

`ifdef BUS_CONFLICT_CNT_EN
    task automatic test_conflict_count();
        req_fp = 24'h3;
        for (int i = 0; i < 300; i++) step();
        total_cnt++;
        if (fp_count !== 8'd255) $display("FAIL count_saturate: got %0d want 255", fp_count);
        else pass_cnt++;
        req_fp = '0; ack_fp = 1;
        step();
        total_cnt++;
        if (fp_count !== 8'd255) $display("FAIL count_ack: got %0d want 255", fp_count);
        else pass_cnt++;
        ack_fp = 0; clear = 1;
        step();
        clear = 0;
        total_cnt++;
        if (fp_count !== 8'd0) $display("FAIL count_clear: got %0d want 0", fp_count);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_single();
        test_fixed_conflict();
        test_hold();
        test_rr_rotate();
        test_clear_mid_hold();
`ifdef BUS_CONFLICT_CNT_EN
        test_conflict_count();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bus_src_arbiter.md
# bus_src_arbiter

Parametrised, registered bus-source selector for the datapath bus multiplexer. It takes one drive-request strobe per bus source and produces a registered binary select code plus a one-hot grant. Fixed-priority or round-robin arbitration is chosen by parameter. A hold input keeps the current source on the bus across multi-cycle transfers, and multi-drive conflicts are detected and flagged.

## Interface
- NUM_SRC, 24, number of bus sources; bit k = source k in the standard order R0..R15, HI, LO, ZHI, ZLO, PC, MDR, Inport, C
- SEL_W, $clog2(NUM_SRC+1), select code width
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- clock  in  1  rising-edge clock
- clear  in  1  reset; synchronous, active-high
- src_req  in  NUM_SRC  per-source drive request (the xxOut strobes)
- hold  in  1  keep the current grant unchanged
- conflict_ack  in  1  clears conflict_sticky
- sel  out  SEL_W  registered code: 0 = no source, k+1 = source k
- sel_valid  out  1  registered; high when sel != 0
- grant  out  NUM_SRC  registered one-hot grant; all-zero when idle
- conflict  out  1  registered; pulses when more than one request was sampled
- conflict_sticky  out  1  set by conflict, held until acknowledged

## Operation
- Arbitration is evaluated every cycle that is not held (held = hold & sel_valid).
- RR_MODE=0: the lowest set index of src_req is granted.
- RR_MODE=1: the search starts at last_ptr+1 and wraps modulo NUM_SRC.
  - last_ptr loads the granted index on every new non-idle grant.
  - last_ptr is unchanged when idle or held.
  - last_ptr resets to NUM_SRC-1, so the first search starts at index 0.
- Idle: src_req == 0 and not held, so sel = 0, grant = 0 and sel_valid = 0.
- Held: sel, grant and last_ptr keep their values, even if the held source drops its request. src_req is ignored.
- hold with sel_valid = 0 has no effect; the block arbitrates normally.
- Conflict detection:
  - Active only when not held.
  - A conflict is popcount(src_req) >= 2.
  - conflict is registered with the grant.
  - conflict_sticky is set on any conflict cycle and cleared by conflict_ack.
  - Set dominates ack in the same cycle.
- Encoding: sel = index+1, zero-extended to SEL_W. grant = 1 << index. sel and grant always agree.
- Reset values: sel = 0, sel_valid = 0, grant = 0, conflict = 0, conflict_sticky = 0, last_ptr = NUM_SRC-1, counter = 0.

## Timing
- Latency is 1 cycle. src_req sampled at edge N appears on sel and grant after edge N.
- No combinational path from any input to any output.
- clear dominates hold, conflict_ack and src_req. An asserted clear forces the reset values at the next edge, including mid-hold.
- The first cycle after clear deasserts arbitrates normally. In RR mode it starts from index 0.
- A hold asserted on the same edge that a grant is being registered takes effect from the next edge. The new grant is kept.

## Configuration
- BUS_CONFLICT_CNT_EN defined:
  - Adds output conflict_count [7:0].
  - Increments on each conflict cycle and saturates at 255.
  - Cleared by clear only; conflict_ack does not clear it.
- BUS_CONFLICT_CNT_EN undefined: the port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package bus_pkg:
  - NUM_BUS_SRC = 24.
  - Source index constants SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C, with values 0..23.
  - Select code constants SEL_NONE = 0, SEL_R0 = 1 .. SEL_C = 24, shared with the bus multiplexer.
- Sub-module bus_prio_pick:
  - Combinational lowest-index picker over a NUM_SRC vector.
  - Outputs are found and index.
  - RR mode instantiates it twice: once on requests masked above last_ptr, once unmasked; the masked result wins if found.

## Test plan
- RR_MODE=0: clear 2 cycles, then src_req = bit 20 (PC) -> after 1 edge sel = 21, grant = 1<<20, sel_valid = 1, conflict = 0.
- RR_MODE=0: src_req = bits 3 and 21 -> sel = 4, conflict pulses 1 cycle, conflict_sticky = 1. Then conflict_ack with src_req = 0 -> sticky = 0, sel = 0.
- RR_MODE=1: bits 0, 5 and 23 held constant for 4 cycles -> sel sequence 1, 6, 24, 1, with a conflict every cycle.
- Hold:
  - Grant MDR (sel = 22), then hold = 1 and src_req switches to R1 for 3 cycles -> sel stays 22, conflict = 0.
  - Drop hold -> next edge sel = 2.
- clear asserted mid-hold with a pending request -> next edge all outputs are at reset values. In RR mode the first post-clear grant takes the lowest requested index.
- BUS_CONFLICT_CNT_EN defined: 300 consecutive conflict cycles -> conflict_count = 255. conflict_ack leaves it at 255; clear -> 0.
